ram_readahead_banked: RTL and testbench
=======================================

RAM_READAHEAD_BANKED -- requirements
Module: ram_readahead_banked

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, byte address width.
REQ-002 SHALL have parameter DATA_W, default 8, byte data width.
REQ-003 SHALL have parameter BANKS_LOG2, default 1, log2 of bank count NB (legal range 1..3).
REQ-004 SHALL have parameter SEG_BITS, default 3, log2 of bytes per bank segment.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 req_valid  input  1  read request present.
REQ-009 req_ready  output  1  block can accept a request.
REQ-010 req_addr  input  ADDR_W  requested byte address.
REQ-011 rsp_valid  output  1  rsp_data valid, one-cycle pulse.
REQ-012 rsp_data  output  DATA_W  read byte.
REQ-013 bank_addr  output  NB*ADDR_W  per-bank address, bank k in slice k.
REQ-014 bank_data  input  NB*DATA_W  per-bank read data, bank k in slice k.
REQ-015 bank_ready  input  NB  per-bank data-valid flags.

Function
REQ-016 The block SHALL split req_addr into offset O = [SEG_BITS-1:0], bank B = next BANKS_LOG2 bits, and line L = remaining upper bits.
REQ-017 For each bank k, bank_addr[k] SHALL be {L + (k < B ? 1 : 0), k, O}, with the line sum taken modulo 2^(ADDR_W-SEG_BITS-BANKS_LOG2).
REQ-018 bank_addr SHALL be registered at request acceptance and held constant until the next acceptance.
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: req_ready=1; on req_valid the block SHALL latch the address, load bank_addr and go to ISSUE.
REQ-021 ISSUE: settle cycle, bank_ready ignored; next state WAIT.
REQ-022 WAIT: when all bank_ready bits are high in the same cycle, the block SHALL capture all NB bank_data slices into the line buffer, set rsp_data to slice B, and go to RESP; otherwise it SHALL stay in WAIT indefinitely.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE.
REQ-024 req_ready SHALL be 0 in every state except IDLE; req_valid SHALL be ignored there.
REQ-025 The miss latency SHALL be 3 cycles from the accepting edge to rsp_valid when bank_ready is already high in WAIT.
REQ-026 rsp_data SHALL hold its value after RESP until the next capture.
REQ-027 The block SHALL ignore bank_ready outside WAIT.

Reset
REQ-028 On reset the state SHALL become IDLE, with req_ready=1, rsp_valid=0, rsp_data=0 and bank_addr=0.
REQ-029 On reset the line buffer and its valid flag SHALL be cleared.
REQ-030 A reset in any state, including WAIT, SHALL abort the transaction with no rsp_valid pulse.

Configuration
REQ-031 With macro RAM_READAHEAD_HIT_EN defined, a request SHALL be served from the line buffer when all three of these hold:
- the buffer is valid;
- O equals the buffered offset;
- {L,B} equals the buffered line/bank pair of bank B.
REQ-032 On such a hit the block SHALL go IDLE->RESP directly (1-cycle latency), with bank_addr unchanged.
REQ-033 Without RAM_READAHEAD_HIT_EN, every request SHALL take the miss path, and no buffer compare logic SHALL be built.

Verification
REQ-034 Defaults, addr 0x000005, banks ready, data0=0xA5 -> bank_addr0=0x000005, bank_addr1=0x00000D; rsp_data=0xA5 with rsp_valid 3 cycles after accept.
REQ-035 addr 0x00000D, data1=0x3C -> bank_addr0=0x000015, bank_addr1=0x00000D; rsp_data=0x3C.
REQ-036 addr 0x1FFFFF -> bank_addr0=0x000007 (line wraps), bank_addr1=0x1FFFFF.
REQ-037 bank_ready1 low for 5 WAIT cycles, req_valid held high -> req_ready=0, no rsp_valid until the cycle after bank_ready1 rises, and no second accept.
REQ-038 reset pulsed in WAIT -> next cycle IDLE, req_ready=1, rsp_valid=0, no response; a repeat of the same addr takes full miss latency.
REQ-039 HIT_EN: addr 0x00000D then 0x000015 -> second rsp_valid 1 cycle after accept with buffered bank0 byte; without the macro, 3 cycles.

Source files
------------

// File: rtl/ram_readahead_banked.sv
// ram_readahead_banked: banked read-ahead byte reader.
// A request address is split into {line, bank, offset}. Every bank gets the
// same offset; banks below the requested bank fetch the following line, so
// one fetch covers NB consecutive segments starting at the requested byte.
// Optional feature: define RAM_READAHEAD_HIT_EN to serve repeat requests
// from the captured line buffer with a 1-cycle latency.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high (req_ready is high only in IDLE). rsp_valid is a
// one-cycle pulse; rsp_data holds until the next capture. bank_ready is
// sampled only in WAIT, and all bits must be high in the same cycle.
module ram_readahead_banked #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 8,
  parameter int BANKS_LOG2 = 1,
  parameter int SEG_BITS   = 3,
  localparam int NB        = 1 << BANKS_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [NB*ADDR_W-1:0] bank_addr,
  input  logic [NB*DATA_W-1:0] bank_data,
  input  logic [NB-1:0]        bank_ready,
  output logic [1:0]           dbg_state
);

  localparam int LW = ADDR_W - SEG_BITS - BANKS_LOG2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [NB*ADDR_W-1:0]    bank_addr_q, bank_addr_d;
  logic [BANKS_LOG2-1:0]   req_bank_q;
  logic [DATA_W-1:0]       rsp_data_q;
  logic [DATA_W-1:0]       cap_byte;
  logic                    load_addr;
  logic                    capture;

  logic [SEG_BITS-1:0]     req_off;
  logic [BANKS_LOG2-1:0]   req_bank;
  logic [LW-1:0]           req_line;
  logic [LW-1:0]           line_k;

  assign req_off  = req_addr[SEG_BITS-1:0];
  assign req_bank = req_addr[SEG_BITS +: BANKS_LOG2];
  assign req_line = req_addr[ADDR_W-1 -: LW];

  // Per-bank fetch addresses for the incoming request (line wraps modulo 2^LW).
  always_comb begin
    bank_addr_d = '0;
    line_k      = '0;
    for (int k = 0; k < NB; k++) begin
      line_k = req_line + {{(LW-1){1'b0}}, (BANKS_LOG2'(k) < req_bank)};
      bank_addr_d[k*ADDR_W +: ADDR_W] = {line_k, BANKS_LOG2'(k), req_off};
    end
  end

  // Byte of the latched bank, taken from the live bank data at capture.
  always_comb begin
    cap_byte = '0;
    for (int k = 0; k < NB; k++) begin
      if (BANKS_LOG2'(k) == req_bank_q) cap_byte = bank_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef RAM_READAHEAD_HIT_EN
  logic [NB*DATA_W-1:0] line_buf_q;
  logic                 buf_valid_q;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_buf;
  logic                 hit;
  logic                 hit_take;

  // Buffered address and byte of the bank addressed by the incoming request.
  always_comb begin
    sel_addr = '0;
    sel_buf  = '0;
    for (int k = 0; k < NB; k++) begin
      if (BANKS_LOG2'(k) == req_bank) begin
        sel_addr = bank_addr_q[k*ADDR_W +: ADDR_W];
        sel_buf  = line_buf_q[k*DATA_W +: DATA_W];
      end
    end
  end

  assign hit = buf_valid_q
            && (sel_addr[SEG_BITS-1:0] == req_off)
            && (sel_addr[ADDR_W-1:SEG_BITS] == req_addr[ADDR_W-1:SEG_BITS]);

  // Line buffer: filled on every miss capture, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_buf_q  <= '0;
      buf_valid_q <= 1'b0;
    end else if (capture) begin
      line_buf_q  <= bank_data;
      buf_valid_q <= 1'b1;
    end
  end
`endif

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    capture   = 1'b0;
`ifdef RAM_READAHEAD_HIT_EN
    hit_take  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef RAM_READAHEAD_HIT_EN
          if (hit) begin
            hit_take = 1'b1;
            state_d  = RESP;
          end else begin
            load_addr = 1'b1;
            state_d   = ISSUE;
          end
`else
          load_addr = 1'b1;
          state_d   = ISSUE;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (&bank_ready) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, fetch addresses and response byte registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bank_addr_q <= '0;
      req_bank_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_addr) begin
        bank_addr_q <= bank_addr_d;
        req_bank_q  <= req_bank;
      end
      if (capture) rsp_data_q <= cap_byte;
`ifdef RAM_READAHEAD_HIT_EN
      if (hit_take) rsp_data_q <= sel_buf;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign bank_addr = bank_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_readahead_banked.sv
// Bench for ram_readahead_banked: directed cases followed by random requests,
// scored against an arithmetic model of the address split and line buffer.
module tb_ram_readahead_banked;
  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 8;
  localparam int BANKS_LOG2 = 1;
  localparam int SEG_BITS   = 3;
  localparam int NB         = 1 << BANKS_LOG2;
  localparam int LW         = ADDR_W - SEG_BITS - BANKS_LOG2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_data;
  logic [NB*ADDR_W-1:0] bank_addr;
  logic [NB*DATA_W-1:0] bank_data;
  logic [NB-1:0]        bank_ready;
  logic [1:0]           dbg_state;

  ram_readahead_banked dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_addr(bank_addr), .bank_data(bank_data), .bank_ready(bank_ready),
    .dbg_state(dbg_state)
  );

  // Clock and cycle count.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rsp_count = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                due_q[$];

  // Reference model state.
  logic [ADDR_W-1:0] m_bank[NB];
  logic [DATA_W-1:0] m_buf[NB];
  bit                m_valid;
  logic [DATA_W-1:0] m_rsp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ref_bank_addr(input logic [ADDR_W-1:0] a, input int k);
    int unsigned l, b, o;
    l = int'(a >> (SEG_BITS + BANKS_LOG2));
    b = int'(a >> SEG_BITS) % NB;
    o = int'(a) % (1 << SEG_BITS);
    l = (l + ((k < b) ? 1 : 0)) % (1 << LW);
    return ADDR_W'((l << (SEG_BITS + BANKS_LOG2)) + (k << SEG_BITS) + o);
  endfunction

  function automatic logic [NB*ADDR_W-1:0] model_flat();
    logic [NB*ADDR_W-1:0] f;
    for (int k = 0; k < NB; k++) f[k*ADDR_W +: ADDR_W] = m_bank[k];
    return f;
  endfunction

  // Monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=rsp_valid data=0x%0h required=no response (cycle %0d)", rsp_data, cyc);
      end else begin
        check("rsp_data", rsp_data, exp_q.pop_front());
        check("rsp_cycle", cyc, due_q.pop_front());
      end
      rsp_count++;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // One request; stall holds the top bank not-ready for that many WAIT cycles
  // while req_valid stays high with other_addr.
  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [NB*DATA_W-1:0] dflat,
                        input int stall, input logic [ADDR_W-1:0] other_addr);
    int  b, base, start;
    bit  hit, done;
    logic [NB*ADDR_W-1:0] exp_ba;
    step();
    check("rsp_hold", rsp_data, m_rsp);
    check("req_ready_idle", req_ready, 1);
    req_addr   = a;
    req_valid  = 1'b1;
    bank_data  = dflat;
    bank_ready = '1;
    if (stall > 0) bank_ready[NB-1] = 1'b0;
    base  = cyc;
    start = rsp_count;
    b     = int'(a >> SEG_BITS) % NB;
    hit   = 1'b0;
`ifdef RAM_READAHEAD_HIT_EN
    hit = m_valid && ((a >> SEG_BITS) == (m_bank[b] >> SEG_BITS))
                  && ((a % (1 << SEG_BITS)) == (m_bank[b] % (1 << SEG_BITS)));
`endif
    if (hit) begin
      m_rsp = m_buf[b];
      exp_q.push_back(m_rsp);
      due_q.push_back(base + 1);
    end else begin
      for (int k = 0; k < NB; k++) begin
        m_bank[k] = ref_bank_addr(a, k);
        m_buf[k]  = dflat[k*DATA_W +: DATA_W];
      end
      m_valid = 1'b1;
      m_rsp   = m_buf[b];
      exp_q.push_back(m_rsp);
      due_q.push_back(base + 3 + stall);
    end
    exp_ba = model_flat();
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      step();
      if (k == 1) begin
        check("bank_addr", bank_addr, exp_ba);
        if (stall > 0) req_addr = other_addr;
        else req_valid = 1'b0;
      end
      check("req_ready_busy", req_ready, 0);
      if (stall > 0) check("bank_addr_held", bank_addr, exp_ba);
      if (k == 2 + stall) bank_ready = '1;
      if (rsp_count != start) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no response required=response for addr 0x%0h", a);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    req_valid  = 1'b0;
    bank_ready = '1;
  endtask

  // Request parked in WAIT, then reset: must abort with no response.
  task automatic do_reset_abort(input logic [ADDR_W-1:0] a, input logic [NB*DATA_W-1:0] dflat);
    int start;
    step();
    start      = rsp_count;
    req_addr   = a;
    req_valid  = 1'b1;
    bank_data  = dflat;
    bank_ready = '0;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("abort_ready_wait", req_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_valid = 1'b0;
    m_rsp   = '0;
    for (int k = 0; k < NB; k++) m_bank[k] = '0;
    check("abort_req_ready", req_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_bank_addr", bank_addr, 0);
    bank_ready = '1;
    repeat (4) step();
    check("abort_no_rsp", rsp_count, start);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a, o;
    logic [NB*DATA_W-1:0] d;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    bank_data  = '0;
    bank_ready = '1;
    m_valid    = 1'b0;
    m_rsp      = '0;
    for (int k = 0; k < NB; k++) begin
      m_bank[k] = '0;
      m_buf[k]  = '0;
    end
    step();
    step();
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_bank_addr", bank_addr, 0);

    do_req(21'h000005, {8'h11, 8'hA5}, 0, '0);
    check("ba_addr05", bank_addr, {21'h00000D, 21'h000005});
    do_req(21'h1FFFFF, {8'h5A, 8'h66}, 0, '0);
    check("ba_wrap", bank_addr, {21'h1FFFFF, 21'h000007});
    do_req(21'h00000D, {8'h3C, 8'h77}, 0, '0);
    check("ba_addr0d", bank_addr, {21'h00000D, 21'h000015});
    check("rsp_3c", rsp_data, 8'h3C);
    do_req(21'h000015, {8'hC3, 8'h99}, 0, '0);
`ifdef RAM_READAHEAD_HIT_EN
    check("hit_data", rsp_data, 8'h77);
`else
    check("miss_data", rsp_data, 8'h99);
`endif
    do_req(21'h000123, {8'hE1, 8'h2D}, 5, 21'h000456);
    do_reset_abort(21'h000040, {8'h10, 8'h20});
    do_req(21'h000040, {8'h10, 8'h20}, 0, '0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = m_bank[$urandom_range(0, NB - 1)];
      else a = ADDR_W'($urandom);
      o = ADDR_W'($urandom);
      d = (NB*DATA_W)'($urandom);
      do_req(a, d, $urandom_range(0, 3), o);
    end

    repeat (4) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
